// File: rtl/seq_divider_if.sv
// Handshake/operand bundle between the multicycle control unit and seq_divider.
// SEQ_DIVIDER_DIVU_EN adds the unsigned_op request qualifier.
interface seq_divider_if;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        done;
   logic        div_zero;
   logic        busy;
`ifdef SEQ_DIVIDER_DIVU_EN
   logic        unsigned_op;

   modport master (output start, a, b, unsigned_op,
                   input  hi, lo, done, div_zero, busy);
   modport slave  (input  start, a, b, unsigned_op,
                   output hi, lo, done, div_zero, busy);
`else
   modport master (output start, a, b,
                   input  hi, lo, done, div_zero, busy);
   modport slave  (input  start, a, b,
                   output hi, lo, done, div_zero, busy);
`endif
endinterface

// File: rtl/seq_divider.sv
// Multicycle restoring divider (MIPS div: LO=quotient, HI=remainder), one quotient bit per cycle.
// Optional unsigned mode (divu) is enabled with SEQ_DIVIDER_DIVU_EN.
module seq_divider (
   input  logic         clk,
   input  logic         reset,
   seq_divider_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] mag_b_q, mag_b_d;
   logic [31:0] r_q, r_d;
   logic [31:0] q_q, q_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic        done_q, done_d;
   logic        div_zero_q, div_zero_d;
   logic        busy_q, busy_d;
   logic        use_unsigned_s;
   logic [32:0] shifted_s;
   logic [33:0] trial_s;

   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic as_unsigned);
      if (as_unsigned || !v[31]) begin
         magnitude = v;
      end else begin
         magnitude = 32'd0 - v;
      end
   endfunction

   function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
      if (neg) begin
         apply_sign = 32'd0 - v;
      end else begin
         apply_sign = v;
      end
   endfunction

`ifdef SEQ_DIVIDER_DIVU_EN
   assign use_unsigned_s = bus.unsigned_op;
`else
   assign use_unsigned_s = 1'b0;
`endif

   // Remainder keeps its shifted-out bit so divisors above 2^31 (divu) still compare correctly.
   assign shifted_s = {r_q, q_q[31]};
   assign trial_s   = {1'b0, shifted_s} - {2'b00, mag_b_q};

   // Next-state and datapath update for the four-state sequencer.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mag_b_d    = mag_b_q;
      r_d        = r_q;
      q_d        = q_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      busy_d     = busy_q;
      case (state_q)
         IDLE: begin
            if (bus.start && (bus.b == 32'd0)) begin
               div_zero_d = 1'b1;
            end else if (bus.start) begin
               state_d   = RUN;
               cnt_d     = 6'd0;
               busy_d    = 1'b1;
               r_d       = 32'd0;
               q_d       = magnitude(bus.a, use_unsigned_s);
               mag_b_d   = magnitude(bus.b, use_unsigned_s);
               neg_quo_d = !use_unsigned_s && (bus.a[31] ^ bus.b[31]);
               neg_rem_d = !use_unsigned_s && bus.a[31];
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (!trial_s[33]) begin
               r_d = trial_s[31:0];
               q_d = {q_q[30:0], 1'b1};
            end else begin
               r_d = shifted_s[31:0];
               q_d = {q_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = FIX;
            end else begin
               state_d = RUN;
            end
         end
         FIX: begin
            lo_d    = apply_sign(q_q, neg_quo_q);
            hi_d    = apply_sign(r_q, neg_rem_q);
            done_d  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= 6'd0;
         mag_b_q    <= 32'd0;
         r_q        <= 32'd0;
         q_q        <= 32'd0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mag_b_q    <= mag_b_d;
         r_q        <= r_d;
         q_q        <= q_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.done     = done_q;
   assign bus.div_zero = div_zero_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against a plain-arithmetic div/divu model.
module tb_seq_divider;
   logic clk;
   logic reset;
   int   total;
   int   bad;
   logic dummy_uns;

   seq_divider_if dif ();

   seq_divider dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: 64-bit signed/unsigned division truncates toward zero, as MIPS div/divu does.
   function automatic void model(input logic [31:0] av, input logic [31:0] bv, input logic uns,
                                 output logic [31:0] q, output logic [31:0] r);
      longint x, y, qq, rr;
      if (uns) begin
         x = longint'({32'd0, av});
         y = longint'({32'd0, bv});
      end else begin
         x = longint'($signed(av));
         y = longint'($signed(bv));
      end
      qq = x / y;
      rr = x % y;
      q  = qq[31:0];
      r  = rr[31:0];
   endfunction

   // Issue one operation; lat counts edges after the accept edge until done is seen.
   task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic uns,
                         input int start_at, output int lat);
      @(negedge clk);
      dif.start = 1'b1;
      dif.a     = av;
      dif.b     = bv;
`ifdef SEQ_DIVIDER_DIVU_EN
      dif.unsigned_op = uns;
`else
      dummy_uns = uns;
`endif
      @(negedge clk);
      dif.start = 1'b0;
      dif.a     = $urandom;
      dif.b     = $urandom;
      lat = 0;
      while (dif.done !== 1'b1 && lat < 60) begin
         if (lat == start_at) begin
            dif.start = 1'b1;
            dif.a     = $urandom;
            dif.b     = $urandom | 32'd1;
         end else begin
            dif.start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      dif.start = 1'b0;
   endtask

   task automatic test_reset;
      reset     = 1'b0;
      dif.start = 1'b0;
      dif.a     = 32'd0;
      dif.b     = 32'd0;
`ifdef SEQ_DIVIDER_DIVU_EN
      dif.unsigned_op = 1'b0;
`endif
      repeat (3) @(negedge clk);
      total += 5;
      if (dif.hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", dif.hi); end
      if (dif.lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", dif.lo); end
      if (dif.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", dif.done); end
      if (dif.div_zero !== 1'b0) begin bad++; $display("FAIL reset_div_zero: got %b want 0", dif.div_zero); end
      if (dif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", dif.busy); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int lat;
      run_op(32'd100, 32'd7, 1'b0, -1, lat);
      total += 4;
      if (lat !== 33) begin bad++; $display("FAIL basic_latency: got %0d want 33", lat); end
      if (dif.lo !== 32'd14) begin bad++; $display("FAIL basic_lo: got %0d want 14", dif.lo); end
      if (dif.hi !== 32'd2) begin bad++; $display("FAIL basic_hi: got %0d want 2", dif.hi); end
      if (dif.busy !== 1'b1) begin bad++; $display("FAIL basic_busy_in_done: got %b want 1", dif.busy); end
      @(negedge clk);
      total += 2;
      if (dif.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", dif.busy); end
      if (dif.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", dif.done); end
   endtask

   task automatic test_signs;
      logic [31:0] tab [4][4];
      int lat;
      tab[0] = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
      tab[1] = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
      tab[2] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
      tab[3] = '{32'd3,        32'hFFFFFFF9, 32'd0,        32'd3};
      for (int i = 0; i < 4; i++) begin
         run_op(tab[i][0], tab[i][1], 1'b0, -1, lat);
         total += 2;
         if (dif.lo !== tab[i][2]) begin bad++; $display("FAIL signs_lo[%0d]: got %h want %h", i, dif.lo, tab[i][2]); end
         if (dif.hi !== tab[i][3]) begin bad++; $display("FAIL signs_hi[%0d]: got %h want %h", i, dif.hi, tab[i][3]); end
      end
   endtask

   task automatic test_div_zero;
      int lat;
      run_op(32'd100, 32'd7, 1'b0, -1, lat);
      @(negedge clk);
      dif.start = 1'b1;
      dif.a     = 32'd5;
      dif.b     = 32'd0;
      @(negedge clk);
      total += 5;
      if (dif.div_zero !== 1'b1) begin bad++; $display("FAIL dz_pulse: got %b want 1", dif.div_zero); end
      if (dif.done !== 1'b0) begin bad++; $display("FAIL dz_done: got %b want 0", dif.done); end
      if (dif.busy !== 1'b0) begin bad++; $display("FAIL dz_busy: got %b want 0", dif.busy); end
      if (dif.hi !== 32'd2) begin bad++; $display("FAIL dz_hi_kept: got %0d want 2", dif.hi); end
      if (dif.lo !== 32'd14) begin bad++; $display("FAIL dz_lo_kept: got %0d want 14", dif.lo); end
      dif.a = 32'd9;
      dif.b = 32'd4;
      @(negedge clk);
      dif.start = 1'b0;
      total += 2;
      if (dif.div_zero !== 1'b0) begin bad++; $display("FAIL dz_single_cycle: got %b want 0", dif.div_zero); end
      if (dif.busy !== 1'b1) begin bad++; $display("FAIL dz_next_accept: got %b want 1", dif.busy); end
      lat = 0;
      while (dif.done !== 1'b1 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      total += 3;
      if (lat !== 33) begin bad++; $display("FAIL dz_next_latency: got %0d want 33", lat); end
      if (dif.lo !== 32'd2) begin bad++; $display("FAIL dz_next_lo: got %0d want 2", dif.lo); end
      if (dif.hi !== 32'd1) begin bad++; $display("FAIL dz_next_hi: got %0d want 1", dif.hi); end
   endtask

   task automatic test_overflow;
      int lat;
      run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, -1, lat);
      total += 2;
      if (dif.lo !== 32'h80000000) begin bad++; $display("FAIL ovf_lo: got %h want 80000000", dif.lo); end
      if (dif.hi !== 32'd0) begin bad++; $display("FAIL ovf_hi: got %h want 0", dif.hi); end
      run_op(32'h80000000, 32'd1, 1'b0, -1, lat);
      total += 2;
      if (dif.lo !== 32'h80000000) begin bad++; $display("FAIL min_by_one_lo: got %h want 80000000", dif.lo); end
      if (dif.hi !== 32'd0) begin bad++; $display("FAIL min_by_one_hi: got %h want 0", dif.hi); end
   endtask

   task automatic test_ignore_start;
      int lat;
      int seen;
      run_op(32'd1000, 32'd9, 1'b0, 4, lat);
      total += 3;
      if (lat !== 33) begin bad++; $display("FAIL ign_latency: got %0d want 33", lat); end
      if (dif.lo !== 32'd111) begin bad++; $display("FAIL ign_lo: got %0d want 111", dif.lo); end
      if (dif.hi !== 32'd1) begin bad++; $display("FAIL ign_hi: got %0d want 1", dif.hi); end
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (dif.busy === 1'b1) seen++;
      end
      total += 1;
      if (seen !== 0) begin bad++; $display("FAIL ign_not_queued: busy cycles %0d want 0", seen); end
   endtask

   task automatic test_reset_mid;
      int seen;
      @(negedge clk);
      dif.start = 1'b1;
      dif.a     = 32'd50;
      dif.b     = 32'd3;
      @(negedge clk);
      dif.start = 1'b0;
      repeat (9) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      total += 4;
      if (dif.hi !== 32'd0) begin bad++; $display("FAIL rst_mid_hi: got %h want 0", dif.hi); end
      if (dif.lo !== 32'd0) begin bad++; $display("FAIL rst_mid_lo: got %h want 0", dif.lo); end
      if (dif.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", dif.busy); end
      if (dif.done !== 1'b0) begin bad++; $display("FAIL rst_mid_done: got %b want 0", dif.done); end
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      repeat (45) begin
         @(negedge clk);
         if (dif.done === 1'b1 || dif.busy === 1'b1) seen++;
      end
      total += 1;
      if (seen !== 0) begin bad++; $display("FAIL rst_mid_discard: active cycles %0d want 0", seen); end
   endtask

   task automatic test_random;
      logic [31:0] av, bv, eq, er;
      int lat;
      for (int i = 0; i < 25; i++) begin
         av = $urandom;
         bv = $urandom;
         if (i % 3 == 0) begin
            bv = $urandom_range(1, 20);
            if ($urandom_range(0, 1) == 1) bv = 32'd0 - bv;
         end
         if (i % 5 == 1) av = $urandom_range(0, 50);
         if (bv == 32'd0) bv = 32'd1;
         model(av, bv, 1'b0, eq, er);
         run_op(av, bv, 1'b0, -1, lat);
         total += 3;
         if (lat !== 33) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want 33", i, lat); end
         if (dif.lo !== eq) begin bad++; $display("FAIL rand_lo[%0d] %h/%h: got %h want %h", i, av, bv, dif.lo, eq); end
         if (dif.hi !== er) begin bad++; $display("FAIL rand_hi[%0d] %h/%h: got %h want %h", i, av, bv, dif.hi, er); end
      end
   endtask

`ifdef SEQ_DIVIDER_DIVU_EN
   task automatic test_divu;
      logic [31:0] av, bv, eq, er;
      logic uns;
      int lat;
      run_op(32'hFFFFFFFF, 32'd2, 1'b1, -1, lat);
      total += 2;
      if (dif.lo !== 32'h7FFFFFFF) begin bad++; $display("FAIL divu_lo: got %h want 7fffffff", dif.lo); end
      if (dif.hi !== 32'd1) begin bad++; $display("FAIL divu_hi: got %h want 1", dif.hi); end
      run_op(32'hFFFFFFFF, 32'd2, 1'b0, -1, lat);
      total += 2;
      if (dif.lo !== 32'd0) begin bad++; $display("FAIL div_signed_lo: got %h want 0", dif.lo); end
      if (dif.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_signed_hi: got %h want ffffffff", dif.hi); end
      for (int i = 0; i < 10; i++) begin
         av  = $urandom;
         bv  = $urandom | 32'd1;
         uns = $urandom_range(0, 1);
         if (i % 2 == 0) bv = bv | 32'h80000000;
         model(av, bv, uns, eq, er);
         run_op(av, bv, uns, -1, lat);
         total += 2;
         if (dif.lo !== eq) begin bad++; $display("FAIL divu_rand_lo[%0d]: got %h want %h", i, dif.lo, eq); end
         if (dif.hi !== er) begin bad++; $display("FAIL divu_rand_hi[%0d]: got %h want %h", i, dif.hi, er); end
      end
      dif.unsigned_op = 1'b0;
   endtask
`endif

   initial begin
      total     = 0;
      bad       = 0;
      dummy_uns = 1'b0;
      test_reset();
      test_basic();
      test_signs();
      test_div_zero();
      test_overflow();
      test_ignore_start();
      test_reset_mid();
      test_random();
`ifdef SEQ_DIVIDER_DIVU_EN
      test_divu();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
